// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch front end with a DEPTH-entry prefetch FIFO.
// Owns the fetch PC, drives the combinational imem address, buffers
// {pc, inst} pairs and hands them to decode over a valid/ready handshake.
// Supports decode back-pressure and branch/jump redirect (flush).
//
// Optional build macro: FETCHQ_BYPASS_EN
//   When defined, an empty queue presents the imem word combinationally
//   (0-cycle fetch-to-decode latency). When undefined, decode only ever
//   sees registered storage (1-cycle latency).
module fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [31:0]     NOP_INST = 32'h0000_0013
) (
  input  logic                       i_clk,
  input  logic                       i_reset_n,
  output logic [XLEN-1:0]            o_imemAddr,
  input  logic [31:0]                i_imemInst,
  input  logic                       i_imemValid,
  input  logic                       i_redirect,
  input  logic [XLEN-1:0]            i_redirectPc,
  output logic                       o_valid,
  output logic [31:0]                o_inst,
  output logic [XLEN-1:0]            o_pc,
  input  logic                       i_ready,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [XLEN-1:0] fetch_pc;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   count;

  logic [XLEN-1:0] pc_mem   [DEPTH];
  logic [31:0]     inst_mem [DEPTH];

  logic head_valid;
  logic full;
  logic deq;
  logic push;
  logic byp_take;
  logic advance;

  // Redirect targets are forced word-aligned; the low bits are dropped.
  logic redirect_pc_unused;
  assign redirect_pc_unused = &i_redirectPc[1:0];

  // Queue status, handshake decode and head presentation.
  always_comb begin
    head_valid = (count != '0);
    full       = (count == DEPTH_C);
    deq        = head_valid & i_ready;
`ifdef FETCHQ_BYPASS_EN
    // Empty queue: the live imem word is offered directly; if decode takes
    // it the word never enters storage.
    byp_take = ~head_valid & i_imemValid & ~i_redirect & i_ready;
    if (head_valid) begin
      o_valid = 1'b1;
      o_inst  = inst_mem[rd_ptr];
      o_pc    = pc_mem[rd_ptr];
    end else if (i_imemValid & ~i_redirect) begin
      o_valid = 1'b1;
      o_inst  = i_imemInst;
      o_pc    = fetch_pc;
    end else begin
      o_valid = 1'b0;
      o_inst  = NOP_INST;
      o_pc    = '0;
    end
`else
    byp_take = 1'b0;
    o_valid  = head_valid;
    o_inst   = head_valid ? inst_mem[rd_ptr] : NOP_INST;
    o_pc     = head_valid ? pc_mem[rd_ptr]   : '0;
`endif
    push    = i_imemValid & ~i_redirect & (~full | deq) & ~byp_take;
    advance = push | byp_take;
  end

  assign o_imemAddr = fetch_pc;
  assign o_count    = count;
  assign o_full     = full;

  // Fetch PC, pointers and occupancy; reset beats redirect beats push/pop.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      fetch_pc <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else if (i_redirect) begin
      fetch_pc <= {i_redirectPc[XLEN-1:2], 2'b00};
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      if (push)    wr_ptr   <= wr_ptr + PW'(1);
      if (deq)     rd_ptr   <= rd_ptr + PW'(1);
      if (advance) fetch_pc <= fetch_pc + XLEN'(4);
      if (push && !deq)      count <= count + CW'(1);
      else if (!push && deq) count <= count - CW'(1);
    end
  end

  // Entry storage; data needs no reset since count gates visibility.
  always_ff @(posedge i_clk) begin
    if (i_reset_n && push) begin
      pc_mem[wr_ptr]   <= fetch_pc;
      inst_mem[wr_ptr] <= i_imemInst;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed + randomized bench for fetch_queue with a
// queue-based reference model and a scoreboard of expected handshakes.
module tb_fetch_queue;

  localparam int          XLEN     = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic clk = 1'b1;
  always #5 clk = ~clk;

  logic        i_reset_n;
  logic [31:0] o_imemAddr;
  logic [31:0] i_imemInst;
  logic        i_imemValid;
  logic        i_redirect;
  logic [31:0] i_redirectPc;
  logic        o_valid;
  logic [31:0] o_inst;
  logic [31:0] o_pc;
  logic        i_ready;
  logic [2:0]  o_count;
  logic        o_full;

  fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC), .NOP_INST(NOP)) dut (
    .i_clk        (clk),
    .i_reset_n    (i_reset_n),
    .o_imemAddr   (o_imemAddr),
    .i_imemInst   (i_imemInst),
    .i_imemValid  (i_imemValid),
    .i_redirect   (i_redirect),
    .i_redirectPc (i_redirectPc),
    .o_valid      (o_valid),
    .o_inst       (o_inst),
    .o_pc         (o_pc),
    .i_ready      (i_ready),
    .o_count      (o_count),
    .o_full       (o_full)
  );

  // Address-derived instruction pattern for the side-effect-free imem.
  function automatic logic [31:0] imem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A00_0000;
  endfunction

  assign i_imemInst = imem_word(o_imemAddr);

  typedef struct {
    bit          known;
    bit          valid;
    logic [2:0]  count;
    bit          full;
    logic [31:0] addr;
    logic [31:0] pc;
    logic [31:0] inst;
  } status_t;

  status_t     st_q[$];
  logic [63:0] sb_q[$];
  logic [63:0] mq[$];
  logic [31:0] mpc = 32'h0;
  bit          known = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // Apply one cycle of inputs and advance the reference model over it.
  task automatic step(input bit rst, input bit iv, input bit rdr, input bit rdy,
                      input logic [31:0] rpc);
    status_t     s;
    logic [63:0] head;
    bit          byp;
    i_reset_n    = ~rst;
    i_imemValid  = iv;
    i_redirect   = rdr;
    i_ready      = rdy;
    i_redirectPc = rpc;
    byp = 1'b0;
`ifdef FETCHQ_BYPASS_EN
    byp = (mq.size() == 0) && iv && !rdr;
`endif
    if (mq.size() > 0) head = mq[0];
    else if (byp)      head = {mpc, imem_word(mpc)};
    else               head = {32'h0, NOP};
    s.known = known;
    s.valid = (mq.size() > 0) || byp;
    s.count = 3'(mq.size());
    s.full  = (mq.size() == DEPTH);
    s.addr  = mpc;
    s.pc    = head[63:32];
    s.inst  = head[31:0];
    st_q.push_back(s);
    if (rst) begin
      mq.delete();
      mpc   = RESET_PC;
      known = 1'b1;
    end else if (known) begin
      if (s.valid && rdy) sb_q.push_back(head);
      if (mq.size() > 0 && rdy) void'(mq.pop_front());
      if (rdr) begin
        mq.delete();
        mpc = {rpc[31:2], 2'b00};
      end else if (byp && rdy) begin
        mpc = mpc + 32'd4;
      end else if (iv && mq.size() < DEPTH) begin
        mq.push_back({mpc, imem_word(mpc)});
        mpc = mpc + 32'd4;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: per-cycle status check plus scoreboard pop on each handshake.
  always @(negedge clk) begin
    status_t     s;
    logic [63:0] e;
    if (st_q.size() > 0) begin
      s = st_q.pop_front();
      if (s.known) begin
        chk("valid", {63'd0, o_valid}, {63'd0, s.valid});
        chk("count", {61'd0, o_count}, {61'd0, s.count});
        chk("full", {63'd0, o_full}, {63'd0, s.full});
        chk("imem_addr", {32'd0, o_imemAddr}, {32'd0, s.addr});
        if (!s.valid) chk("empty_out", {o_pc, o_inst}, {s.pc, s.inst});
      end
    end
    if (i_reset_n === 1'b1 && o_valid === 1'b1 && i_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_pop: got pc %h inst %h expected no handshake", o_pc, o_inst);
      end else begin
        e = sb_q.pop_front();
        chk("pop_pc_inst", {o_pc, o_inst}, e);
      end
    end
  end

  initial begin
    i_reset_n = 1'b0; i_imemValid = 1'b0; i_redirect = 1'b0;
    i_ready = 1'b0; i_redirectPc = '0;
    // Reset, then streaming with decode always ready.
    repeat (2) step(1, 1, 0, 1, 32'h0);
    repeat (8) step(0, 1, 0, 1, 32'h0);
    // Back-pressure until full, then drain while fetching (full push+pop).
    step(1, 1, 0, 1, 32'h0);
    repeat (10) step(0, 1, 0, 0, 32'h0);
    repeat (8)  step(0, 1, 0, 1, 32'h0);
    // Redirect to misaligned target with three entries queued.
    step(1, 1, 0, 1, 32'h0);
    repeat (3) step(0, 1, 0, 0, 32'h0);
    step(0, 1, 1, 0, 32'h0000_0103);
    repeat (4) step(0, 1, 0, 1, 32'h0);
    // Redirect while a handshake completes and imem is not valid.
    repeat (2) step(0, 1, 0, 0, 32'h0);
    step(0, 0, 1, 1, 32'h0000_0402);
    repeat (3) step(0, 1, 0, 1, 32'h0);
    // Wait states: imem valid 1,0,0,1.
    step(1, 1, 0, 1, 32'h0);
    step(0, 1, 0, 0, 32'h0);
    step(0, 0, 0, 0, 32'h0);
    step(0, 0, 0, 0, 32'h0);
    step(0, 1, 0, 0, 32'h0);
    repeat (3) step(0, 0, 0, 1, 32'h0);
    // Reset beats a simultaneous redirect with two entries queued.
    repeat (2) step(0, 1, 0, 0, 32'h0);
    step(1, 1, 1, 1, 32'h0000_0200);
    repeat (3) step(0, 1, 0, 1, 32'h0);
    // Fetch PC wrap at the top of the address space.
    step(0, 1, 1, 1, 32'hFFFF_FFF9);
    repeat (4) step(0, 1, 0, 0, 32'h0);
    repeat (4) step(0, 1, 0, 1, 32'h0);
    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 15) == 0, $urandom_range(0, 2) != 0, $urandom);
    end
    repeat (8) step(0, 0, 0, 1, 32'h0);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
